// File: rtl/tensor_core_pkg.sv
// Shared types for the tensor core operand/result sequencer.
package tensor_core_pkg;

  localparam int TC_DIM   = 4;
  localparam int TC_ELEMS = 16;
  localparam int TC_REGS  = 32;
  localparam int TC_DW    = 8;

  typedef logic [4:0] tc_addr_t;

  typedef logic [TC_DIM-1:0][TC_DIM-1:0][TC_DW-1:0] tc_matrix_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FLUSH,
    COMPUTE,
    SETTLE,
    DRAIN
  } tc_seq_state_t;

endpackage

// File: rtl/tc_result_drain.sv
// Result snapshot buffer and valid/ready result stream.
module tc_result_drain
  import tensor_core_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  capture_i,
  input  logic [TC_DIM-1:0][TC_DIM-1:0][DATA_WIDTH-1:0] matrix_i,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic [3:0]            out_index_o,
  output logic                  out_valid_o,
  output logic                  last_o
);

  logic [TC_DIM-1:0][TC_DIM-1:0][DATA_WIDTH-1:0] snap_q;
  logic [3:0] cnt_q;
  logic       valid_q;
  logic       hs;

  assign hs = valid_q & out_ready_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      snap_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else if (capture_i) begin
      snap_q  <= matrix_i;
      cnt_q   <= '0;
      valid_q <= 1'b1;
    end else if (hs) begin
      if (cnt_q == 4'(TC_ELEMS - 1)) begin
        cnt_q   <= '0;
        valid_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q + 4'd1;
      end
    end
  end

  assign out_data_o  = snap_q[cnt_q[3:2]][cnt_q[1:0]];
  assign out_index_o = cnt_q;
  assign out_valid_o = valid_q;
  assign last_o      = hs & (cnt_q == 4'(TC_ELEMS - 1));

endmodule

// File: rtl/tensor_core_sequencer.sv
// Load operands, pulse bulk commit, settle, then stream 16 results.
module tensor_core_sequencer
  import tensor_core_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                  clock_in,
  input  logic                  reset_in,
  input  logic                  start_in,
  input  logic                  reuse_b_in,
  output logic                  busy_out,
  output logic                  done_out,
  input  logic [DATA_WIDTH-1:0] in_data_in,
  input  logic                  in_valid_in,
  output logic                  in_ready_out,
  output logic                  tc_nb_we_out,
  output logic [4:0]            tc_nb_addr_out,
  output logic [DATA_WIDTH-1:0] tc_nb_data_out,
  output logic                  tc_bulk_we_out,
  input  logic [TC_DIM-1:0][TC_DIM-1:0][DATA_WIDTH-1:0] tc_result_in,
  output logic [DATA_WIDTH-1:0] out_data_out,
  output logic [3:0]            out_index_out,
  output logic                  out_valid_out,
  input  logic                  out_ready_in
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

  tc_seq_state_t         state_q;
  tc_addr_t              load_cnt_q;
  logic                  reuse_q;
  logic [SW-1:0]         settle_cnt_q;
  logic                  nb_we_q;
  tc_addr_t              nb_addr_q;
  logic [DATA_WIDTH-1:0] nb_data_q;
  logic                  bulk_q;
  logic                  done_q;
  logic                  capture;
  logic                  drain_last;
  tc_addr_t              last_addr;

  assign last_addr = reuse_q ? tc_addr_t'(TC_ELEMS - 1)
                             : tc_addr_t'(TC_REGS - 1);
  assign capture   = (state_q == SETTLE) & (settle_cnt_q == SETTLE_LAST);

  always_ff @(posedge clock_in) begin
    if (!reset_in) begin
      state_q      <= IDLE;
      load_cnt_q   <= '0;
      reuse_q      <= 1'b0;
      settle_cnt_q <= '0;
      nb_we_q      <= 1'b0;
      nb_addr_q    <= '0;
      nb_data_q    <= '0;
      bulk_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      nb_we_q <= 1'b0;
      bulk_q  <= 1'b0;
      done_q  <= 1'b0;
      unique case (state_q)
        IDLE: if (start_in) begin
          reuse_q    <= reuse_b_in;
          load_cnt_q <= '0;
          state_q    <= LOAD;
        end
        LOAD: if (in_valid_in) begin
          nb_we_q   <= 1'b1;
          nb_addr_q <= load_cnt_q;
          nb_data_q <= in_data_in;
          if (load_cnt_q == last_addr) state_q <= FLUSH;
          else load_cnt_q <= load_cnt_q + 5'd1;
        end
        FLUSH: begin
          bulk_q  <= 1'b1;
          state_q <= COMPUTE;
        end
        COMPUTE: begin
          settle_cnt_q <= '0;
          state_q      <= SETTLE;
        end
        SETTLE: begin
          if (capture) state_q <= DRAIN;
          else settle_cnt_q <= settle_cnt_q + SW'(1);
        end
        DRAIN: if (drain_last) begin
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  tc_result_drain #(.DATA_WIDTH(DATA_WIDTH)) u_drain (
    .clk_i       (clock_in),
    .rst_ni      (reset_in),
    .capture_i   (capture),
    .matrix_i    (tc_result_in),
    .out_ready_i (out_ready_in),
    .out_data_o  (out_data_out),
    .out_index_o (out_index_out),
    .out_valid_o (out_valid_out),
    .last_o      (drain_last)
  );

  assign busy_out       = (state_q != IDLE);
  assign in_ready_out   = (state_q == LOAD);
  assign done_out       = done_q;
  assign tc_nb_we_out   = nb_we_q;
  assign tc_nb_addr_out = nb_addr_q;
  assign tc_nb_data_out = nb_data_q;
  assign tc_bulk_we_out = bulk_q;

endmodule

// File: tb/tb_tensor_core_sequencer.sv
// Randomized bench with a transaction-level reference model.
module tb_tensor_core_sequencer;

  localparam int SETTLE = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic reuse = 1'b0;
  logic [7:0] in_data = '0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic busy, done, in_ready, nb_we, bulk_we, out_valid;
  logic [4:0] nb_addr;
  logic [7:0] nb_data, out_data;
  logic [3:0] out_index;
  logic [3:0][3:0][7:0] bank0 = '0;
  logic [3:0][3:0][7:0] commit = '0;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  tensor_core_sequencer #(.DATA_WIDTH(8), .SETTLE_CYCLES(SETTLE)) dut (
    .clock_in       (clk),
    .reset_in       (rst_n),
    .start_in       (start),
    .reuse_b_in     (reuse),
    .busy_out       (busy),
    .done_out       (done),
    .in_data_in     (in_data),
    .in_valid_in    (in_valid),
    .in_ready_out   (in_ready),
    .tc_nb_we_out   (nb_we),
    .tc_nb_addr_out (nb_addr),
    .tc_nb_data_out (nb_data),
    .tc_bulk_we_out (bulk_we),
    .tc_result_in   (bank0),
    .out_data_out   (out_data),
    .out_index_out  (out_index),
    .out_valid_out  (out_valid),
    .out_ready_in   (out_ready)
  );

  // Register file stand-in: bank 0 reflects writes, bulk commit loads the op result.
  always @(posedge clk) begin
    if (nb_we && !nb_addr[4]) bank0[nb_addr[3:2]][nb_addr[1:0]] <= nb_data;
    if (bulk_we) bank0 <= commit;
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: operation-level bookkeeping of what must appear next.
  bit m_busy = 0, m_load = 0, m_drain = 0;
  int m_n = 0, m_beats = 0, m_tail = 0, m_idx = 0;
  bit e_nb = 0, e_bulk = 0, e_done = 0;
  int e_addr = 0, e_ndata = 0;
  logic [3:0][3:0][7:0] m_commit = '0;

  always @(posedge clk) begin
    e_nb = 0; e_bulk = 0; e_done = 0;
    if (!rst_n) begin
      m_busy = 0; m_load = 0; m_drain = 0; m_tail = 0; m_idx = 0;
    end else if (!m_busy) begin
      if (start) begin
        m_busy = 1; m_load = 1; m_beats = 0;
        m_n = reuse ? 16 : 32;
        m_commit = commit;
      end
    end else if (m_load) begin
      if (in_valid) begin
        e_nb = 1; e_addr = m_beats; e_ndata = int'(in_data);
        m_beats++;
        if (m_beats == m_n) begin
          m_load = 0; m_tail = 2 + SETTLE;
        end
      end
    end else if (!m_drain) begin
      m_tail--;
      e_bulk = (m_tail == 1 + SETTLE);
      if (m_tail == 0) begin m_drain = 1; m_idx = 0; end
    end else if (out_ready) begin
      if (m_idx == 15) begin
        m_drain = 0; m_busy = 0; e_done = 1;
      end else m_idx++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", busy, m_busy);
      check("in_ready", in_ready, m_load);
      check("nb_we", nb_we, e_nb);
      check("bulk_we", bulk_we, e_bulk);
      check("done", done, e_done);
      check("out_valid", out_valid, m_drain);
      check("we_excl", nb_we & bulk_we, 0);
      if (e_nb) begin
        check("nb_addr", nb_addr, e_addr);
        check("nb_data", nb_data, e_ndata);
      end
      if (m_drain) begin
        check("out_index", out_index, m_idx);
        check("out_data", out_data, m_commit[m_idx/4][m_idx%4]);
      end
    end
  end

  int lat, max_addr, bulk_cnt, w31;
  logic [7:0] obs [16];

  // ready_mode: 0 always ready, 1 pattern 1-0-0-1, 2 random
  task automatic run_op(input bit rb, input int gap_pct, input int ready_mode,
                        input bit hold, input bit directed);
    int beat = 0;
    bit fin = 0;
    lat = -1; max_addr = 0; bulk_cnt = 0; w31 = -1;
    @(negedge clk);
    start = 1'b1; reuse = rb; out_ready = 1'b1; in_valid = 1'b0;
    for (int n = 1; n < 3000 && !fin; n++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      if (out_valid && lat < 0) lat = n;
      if (out_valid && out_ready) obs[out_index] = out_data;
      if (nb_we && int'(nb_addr) > max_addr) max_addr = int'(nb_addr);
      if (nb_we && nb_addr == 5'd31) w31 = int'(nb_data);
      if (bulk_we) bulk_cnt++;
      if (done) fin = 1;
      in_valid = ($urandom_range(99) >= gap_pct);
      in_data = directed ? 8'(beat + 1) : 8'($urandom);
      if (in_ready && in_valid) beat++;
      unique case (ready_mode)
        0: out_ready = 1'b1;
        1: out_ready = !((n % 4 == 1) || (n % 4 == 2));
        default: out_ready = ($urandom_range(99) >= 35);
      endcase
    end
    start = 1'b0;
    tests++;
    if (!fin) begin
      fails++;
      $display("FAIL op_timeout got=no_done want=done");
    end
    check("bulk_per_op", bulk_cnt, 1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("rst_busy", busy, 0);
    check("rst_nb_we", nb_we, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) commit[i][j] = 8'(8 * i + j);
    run_op(0, 0, 0, 0, 1);
    check("full_latency", lat, 38);
    check("full_w31", w31, 32);
    check("full_maxaddr", max_addr, 31);
    check("res_idx1", obs[1], 1);
    check("res_idx4", obs[4], 8);
    check("res_idx15", obs[15], 27);

    for (int k = 0; k < 16; k++) commit[k/4][k%4] = 8'($urandom);
    run_op(1, 0, 0, 0, 1);
    check("reuse_latency", lat, 22);
    check("reuse_maxaddr", max_addr, 15);

    for (int k = 0; k < 16; k++) commit[k/4][k%4] = 8'($urandom);
    run_op(0, 30, 1, 1, 0);

    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < 16; k++) commit[k/4][k%4] = 8'($urandom);
      run_op(1'($urandom_range(1)), $urandom_range(50), 2,
             1'($urandom_range(1)), 0);
    end

    // Abort mid-load with reset, then restart cleanly.
    @(negedge clk);
    start = 1'b1; reuse = 1'b0;
    begin
      int beats = 0;
      for (int n = 0; n < 200 && beats < 10; n++) begin
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b1; in_data = 8'($urandom);
        if (in_ready) beats++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_in_ready", in_ready, 0);
    check("abort_nb_we", nb_we, 0);
    check("abort_nb_addr", nb_addr, 0);
    check("abort_nb_data", nb_data, 0);
    rst_n = 1'b1;
    for (int k = 0; k < 16; k++) commit[k/4][k%4] = 8'($urandom);
    run_op(0, 20, 2, 0, 0);
    check("restart_maxaddr", max_addr, 31);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
